oam_scan: RTL and testbench

- PPU-side reader of sprite attribute memory for mode 2 (OAM search).
- On each scanline start, the block walks all 40 OAM entries at 2 dots per entry, 80 dots in total.
- It compares each entry's Y against the current line and records the first 10 hits (entry index, Y, X) in a line sprite buffer.
- The pixel fetcher reads the buffer during mode 3.

---
 rtl/gb_ppu_pkg.sv | 27 ++
 rtl/oam_scan_if.sv | 28 ++
 rtl/line_sprite_buffer.sv | 36 +++
 rtl/oam_scan.sv | 122 ++++++++++++
 tb/tb_oam_scan.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/gb_ppu_pkg.sv
// Shared PPU types and constants: OAM geometry, line sprite entries, scan FSM states.
package gb_ppu_pkg;

  localparam int unsigned OAM_ENTRIES      = 40;
  localparam int unsigned MAX_LINE_SPRITES = 10;
  localparam int unsigned OBJ_Y_OFFSET     = 16;

  typedef struct packed {
    logic [5:0] index;
    logic [7:0] y;
    logic [7:0] x;
  } sprite_entry_t;

  typedef enum logic [1:0] {IDLE, SCAN_Y, SCAN_X, DONE} oam_scan_state_t;

  // Sprite Y is stored offset by 16; 9-bit math so high Y values never wrap into range.
  function automatic logic obj_y_hit(logic [7:0] y, logic [7:0] ly, logic tall);
    logic [8:0] l;
    logic [8:0] h;
    logic [8:0] top;
    l   = {1'b0, ly} + 9'(OBJ_Y_OFFSET);
    h   = tall ? 9'd16 : 9'd8;
    top = {1'b0, y} + h;
    return ({1'b0, y} <= l) && (l < top);
  endfunction

endpackage

// File: rtl/oam_scan_if.sv
// Bundle between the PPU control side and the OAM scanner: control, OAM bus, buffer read.
interface oam_scan_if;

  logic       dot_en;
  logic       start;
  logic [7:0] ly;
  logic       obj_size;
  logic [7:0] oam_addr;
  logic [7:0] oam_rdata;
  logic       busy;
  logic       done;
  logic [3:0] sprite_count;
  logic [3:0] slot_sel;
  logic [5:0] slot_index;
  logic [7:0] slot_y;
  logic [7:0] slot_x;

  modport slave (
    input  dot_en, start, ly, obj_size, oam_rdata, slot_sel,
    output oam_addr, busy, done, sprite_count, slot_index, slot_y, slot_x
  );

  modport master (
    output dot_en, start, ly, obj_size, oam_rdata, slot_sel,
    input  oam_addr, busy, done, sprite_count, slot_index, slot_y, slot_x
  );

endinterface

// File: rtl/line_sprite_buffer.sv
// Per-line sprite register file: one synchronous write port, one combinational read port.
module line_sprite_buffer
  import gb_ppu_pkg::*;
#(
  parameter int unsigned Depth = MAX_LINE_SPRITES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [3:0]    waddr_i,
  input  sprite_entry_t wdata_i,
  input  logic [3:0]    raddr_i,
  output sprite_entry_t rdata_o
);

  sprite_entry_t mem_q [Depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(waddr_i) < Depth)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Selects past the last physical slot read as zero.
  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < Depth) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/oam_scan.sv
// Mode-2 OAM search: walks every OAM entry at two dots each, keeping the first hits per line.
module oam_scan
  import gb_ppu_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = OAM_ENTRIES,
  parameter int unsigned MAX_SPRITES = MAX_LINE_SPRITES
) (
  input logic       clk,
  input logic       reset,
  oam_scan_if.slave scan_io
);

  oam_scan_state_t state_q, state_d;
  logic [5:0]      entry_q, entry_d;
  logic [3:0]      count_q, count_d;
  logic [7:0]      ly_q, ly_d;
  logic            tall_q, tall_d;
  logic [7:0]      y_lat_q, y_lat_d;

  logic            buf_we;
  sprite_entry_t   buf_wdata;
  sprite_entry_t   buf_rdata;
  logic [7:0]      oam_addr;
  logic            busy;
  logic            done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      entry_q <= '0;
      count_q <= '0;
      ly_q    <= '0;
      tall_q  <= 1'b0;
      y_lat_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      ly_q    <= ly_d;
      tall_q  <= tall_d;
      y_lat_q <= y_lat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    count_d  = count_q;
    ly_d     = ly_q;
    tall_d   = tall_q;
    y_lat_d  = y_lat_q;
    buf_we   = 1'b0;
    oam_addr = '0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (scan_io.dot_en && scan_io.start) begin
          ly_d    = scan_io.ly;
          tall_d  = scan_io.obj_size;
          count_d = '0;
          entry_d = '0;
          state_d = SCAN_Y;
        end
      end
      SCAN_Y: begin
        busy     = 1'b1;
        oam_addr = {entry_q, 2'b00};
        if (scan_io.dot_en) begin
          y_lat_d = scan_io.oam_rdata;
          state_d = SCAN_X;
        end
      end
      SCAN_X: begin
        busy     = 1'b1;
        oam_addr = {entry_q, 2'b01};
        if (scan_io.dot_en) begin
          // A full buffer drops hits but the walk continues so mode 2 stays 80 dots.
          if (obj_y_hit(y_lat_q, ly_q, tall_q) && (count_q < 4'(MAX_SPRITES))) begin
            buf_we  = 1'b1;
            count_d = count_q + 4'd1;
          end
          if (entry_q == 6'(NUM_ENTRIES - 1)) begin
            state_d = DONE;
          end else begin
            entry_d = entry_q + 6'd1;
            state_d = SCAN_Y;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign buf_wdata = '{index: entry_q, y: y_lat_q, x: scan_io.oam_rdata};

  line_sprite_buffer #(
    .Depth (MAX_SPRITES)
  ) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .we_i    (buf_we),
    .waddr_i (count_q),
    .wdata_i (buf_wdata),
    .raddr_i (scan_io.slot_sel),
    .rdata_o (buf_rdata)
  );

  assign scan_io.oam_addr     = oam_addr;
  assign scan_io.busy         = busy;
  assign scan_io.done         = done;
  assign scan_io.sprite_count = count_q;
  assign scan_io.slot_index   = buf_rdata.index;
  assign scan_io.slot_y       = buf_rdata.y;
  assign scan_io.slot_x       = buf_rdata.x;

endmodule

// File: tb/tb_oam_scan.sv
// Directed bench for oam_scan: OAM modelled as a byte array, expectations hand-computed.
module tb_oam_scan;

  logic clk;
  logic reset;

  oam_scan_if bus ();

  logic [7:0] oam [160];

  assign bus.oam_rdata = (bus.oam_addr < 8'd160) ? oam[bus.oam_addr] : 8'h00;

  oam_scan dut (
    .clk     (clk),
    .reset   (reset),
    .scan_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int first_done;
  int done_n;
  int busy_n;
  int hold_err;
  int addr_q [$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 160; i++) oam[i] = 8'h00;
  endtask

  task automatic chk_slot(input string tag, input int s, input int idx, input int y, input int x);
    bus.slot_sel = 4'(s);
    #1;
    chk({tag, ".index"}, int'(bus.slot_index), idx);
    chk({tag, ".y"}, int'(bus.slot_y), y);
    chk({tag, ".x"}, int'(bus.slot_x), x);
  endtask

  // Starts a scan at a negedge and follows it until one cycle past done (or stop_at).
  // k counts negedges after the start-accepting edge; dot_en is high on edges k%div==0.
  task automatic run_scan(input int div, input logic [7:0] line, input logic tall,
                          input int start_again_at, input int stop_at);
    logic [7:0] prev_addr;
    logic       prev_en;
    first_done = -1;
    done_n     = 0;
    busy_n     = 0;
    hold_err   = 0;
    addr_q.delete();
    @(negedge clk);
    bus.dot_en   = 1'b1;
    bus.start    = 1'b1;
    bus.ly       = line;
    bus.obj_size = tall;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.ly       = line ^ 8'h55;
    bus.obj_size = ~tall;
    prev_addr    = '0;
    prev_en      = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (k == stop_at) return;
      if (bus.done) begin
        done_n++;
        if (first_done < 0) first_done = k;
      end
      if (bus.busy && k > 0 && !prev_en && bus.oam_addr != prev_addr) hold_err++;
      if (first_done >= 0 && k > first_done) return;
      bus.dot_en = ((k + 1) % div) == 0;
      bus.start  = (k == start_again_at);
      if (bus.busy && bus.dot_en) begin
        busy_n++;
        addr_q.push_back(int'(bus.oam_addr));
      end
      prev_addr = bus.oam_addr;
      prev_en   = bus.dot_en;
      @(negedge clk);
    end
  endtask

  initial begin
    int seq_err;
    reset        = 1'b1;
    bus.dot_en   = 1'b0;
    bus.start    = 1'b0;
    bus.ly       = '0;
    bus.obj_size = 1'b0;
    bus.slot_sel = '0;
    clear_oam();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.busy", int'(bus.busy), 0);
    chk("reset.done", int'(bus.done), 0);
    chk("reset.count", int'(bus.sprite_count), 0);
    chk("reset.addr", int'(bus.oam_addr), 0);
    chk_slot("reset.slot0", 0, 0, 0, 0);
    reset = 1'b0;

    // Basic hit, with a start pulse mid-scan that must be ignored.
    oam[12] = 8'd16;
    oam[13] = 8'd8;
    run_scan(1, 8'd0, 1'b0, 10, -1);
    chk("basic.done_at", first_done, 80);
    chk("basic.done_n", done_n, 1);
    chk("basic.busy_dots", busy_n, 80);
    chk("basic.count", int'(bus.sprite_count), 1);
    chk_slot("basic.slot0", 0, 3, 16, 8);
    chk_slot("basic.slot1", 1, 0, 0, 0);

    // Height boundaries for 8x8 and 8x16.
    clear_oam();
    oam[0] = 8'd16;
    run_scan(1, 8'd7, 1'b0, -1, -1);
    chk("h8.ly7", int'(bus.sprite_count), 1);
    run_scan(1, 8'd8, 1'b0, -1, -1);
    chk("h8.ly8", int'(bus.sprite_count), 0);
    run_scan(1, 8'd15, 1'b1, -1, -1);
    chk("h16.ly15", int'(bus.sprite_count), 1);
    run_scan(1, 8'd16, 1'b1, -1, -1);
    chk("h16.ly16", int'(bus.sprite_count), 0);

    // Overflow: every entry hits, only the first ten are kept.
    for (int i = 0; i < 40; i++) begin
      oam[4*i]   = 8'd20;
      oam[4*i+1] = 8'(i);
    end
    run_scan(1, 8'd10, 1'b0, -1, -1);
    chk("ovf.count", int'(bus.sprite_count), 10);
    chk("ovf.done_at", first_done, 80);
    for (int s = 0; s < 10; s++) chk_slot($sformatf("ovf.slot%0d", s), s, s, 20, s);
    chk_slot("ovf.slot12", 12, 0, 0, 0);

    // dot_en gating 1-of-4: address walk and stretched completion.
    run_scan(4, 8'd10, 1'b0, -1, -1);
    chk("gate.done_at", first_done, 320);
    chk("gate.done_n", done_n, 1);
    chk("gate.addr_len", addr_q.size(), 80);
    seq_err = 0;
    for (int i = 0; i < addr_q.size() && i < 80; i++) begin
      if (addr_q[i] != (4 * (i / 2) + (i % 2))) seq_err++;
    end
    chk("gate.addr_seq", seq_err, 0);
    chk("gate.addr_hold", hold_err, 0);
    chk("gate.count", int'(bus.sprite_count), 10);

    // Reset partway through a scan.
    run_scan(1, 8'd10, 1'b0, -1, 29);
    chk("rst.busy_before", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.count", int'(bus.sprite_count), 0);
    chk("rst.addr", int'(bus.oam_addr), 0);
    chk_slot("rst.slot0", 0, 0, 0, 0);
    done_n = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.done) done_n++;
      @(negedge clk);
    end
    chk("rst.no_done", done_n, 0);

    // High Y: l must reach 160 before entry 5 hits.
    clear_oam();
    oam[20] = 8'd160;
    oam[21] = 8'd200;
    run_scan(1, 8'd143, 1'b1, -1, -1);
    chk("highy.ly143", int'(bus.sprite_count), 0);
    run_scan(1, 8'd144, 1'b1, -1, -1);
    chk("highy.ly144", int'(bus.sprite_count), 1);
    chk_slot("highy.slot0", 0, 5, 160, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
